// File: rtl/lcd1602_bus_driver.sv
// rtl/lcd1602_bus_driver.sv - LCD1602 (HD44780) write-cycle driver behind the iCall/oDone handshake
//
// Purpose: accepts one byte plus RS per request, plays it onto the LCD pins as a
// timed write cycle (setup, EN pulse, hold), waits out the controller's execution
// time, then pulses oDone for one cycle.
//
// Optional feature macro: LCD1602_BUSY_POLL_EN
//   undefined : LCD1602_D is an output, LCD1602_RW is tied 0, post-write wait is a fixed delay
//   defined   : LCD1602_D is inout, post-write wait is a busy-flag poll capped at T_LONG_CYC
//
// Ports:
//   CLOCK       in   1  system clock
//   RST         in   1  synchronous active-high reset
//   iCall       in   1  request, held by requester until oDone is seen
//   iRS         in   1  0 = instruction, 1 = data (captured with iDATA)
//   iDATA       in   8  byte to write (captured on accept)
//   oDone       out  1  one-cycle pulse when the LCD can take the next byte
//   oReady      out  1  high once the power-up wait has elapsed
//   LCD1602_RS  out  1  register select
//   LCD1602_RW  out  1  0 = write, 1 = read
//   LCD1602_EN  out  1  enable strobe
//   LCD1602_D   out  8  data bus (inout with LCD1602_BUSY_POLL_EN)

module lcd1602_bus_driver #(
    parameter int T_POWERUP_CYC = 750000,
    parameter int T_SETUP_CYC   = 4,
    parameter int T_EN_CYC      = 25,
    parameter int T_HOLD_CYC    = 4,
    parameter int T_EXEC_CYC    = 2500,
    parameter int T_LONG_CYC    = 100000
) (
    input  logic       CLOCK,
    input  logic       RST,
    input  logic       iCall,
    input  logic       iRS,
    input  logic [7:0] iDATA,
    output logic       oDone,
    output logic       oReady,
    output logic       LCD1602_RS,
    output logic       LCD1602_RW,
    output logic       LCD1602_EN,
`ifdef LCD1602_BUSY_POLL_EN
    inout  wire  [7:0] LCD1602_D
`else
    output logic [7:0] LCD1602_D
`endif
);

    localparam int M1      = (T_POWERUP_CYC > T_LONG_CYC) ? T_POWERUP_CYC : T_LONG_CYC;
    localparam int M2      = (M1 > T_EXEC_CYC) ? M1 : T_EXEC_CYC;
    localparam int M3      = (M2 > T_EN_CYC) ? M2 : T_EN_CYC;
    localparam int M4      = (M3 > T_SETUP_CYC) ? M3 : T_SETUP_CYC;
    localparam int CNT_MAX = (M4 > T_HOLD_CYC) ? M4 : T_HOLD_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(T_POWERUP_CYC - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC_CYC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_LONG_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [3:0] {
        S_PWRUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_DONE,
        S_POLL_SETUP,
        S_POLL_PULSE,
        S_POLL_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          rs_q, rs_d;
    logic          en_q, en_d;
    logic [7:0]    dout_q, dout_d;
    logic          is_long;

`ifdef LCD1602_BUSY_POLL_EN
    logic          rw_q, rw_d;
    logic          drive_q, drive_d;
    logic          bf_q, bf_d;
    logic [CW-1:0] poll_q, poll_d;
`endif

    // The bus registers still hold the accepted request during HOLD, so they
    // double as the latch used to pick the long (clear/home) wait.
    assign is_long = !rs_q && (dout_q == 8'h01 || dout_q == 8'h02 || dout_q == 8'h03);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        rs_d    = rs_q;
        en_d    = en_q;
        dout_d  = dout_q;
`ifdef LCD1602_BUSY_POLL_EN
        rw_d    = rw_q;
        drive_d = drive_q;
        bf_d    = bf_q;
        poll_d  = poll_q;
`endif
        case (state_q)
            // Reset clears the counter, so power-up counts upward to its limit.
            S_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_IDLE: begin
                if (iCall) begin
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    rs_d    = iRS;
                    dout_d  = iDATA;
                    en_d    = 1'b0;
`ifdef LCD1602_BUSY_POLL_EN
                    rw_d    = 1'b0;
                    drive_d = 1'b1;
`endif
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = LD_EN;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = LD_HOLD;
                    en_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
`ifdef LCD1602_BUSY_POLL_EN
                    state_d = S_POLL_SETUP;
                    cnt_d   = LD_SETUP;
                    poll_d  = LD_LONG;
                    rs_d    = 1'b0;
                    rw_d    = 1'b1;
                    drive_d = 1'b0;
`else
                    state_d = S_WAIT;
                    cnt_d   = is_long ? LD_LONG : LD_EXEC;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
`ifdef LCD1602_BUSY_POLL_EN
            // poll_q counts every cycle spent polling; reaching zero ends the
            // wait no matter where in the read cycle we are.
            S_POLL_SETUP, S_POLL_PULSE, S_POLL_HOLD: begin
                if (poll_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    en_d    = 1'b0;
                end else begin
                    poll_d = poll_q - CNT_ONE;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (state_q == S_POLL_SETUP) begin
                        state_d = S_POLL_PULSE;
                        cnt_d   = LD_EN;
                        en_d    = 1'b1;
                    end else if (state_q == S_POLL_PULSE) begin
                        state_d = S_POLL_HOLD;
                        cnt_d   = LD_HOLD;
                        en_d    = 1'b0;
                        bf_d    = LCD1602_D[7];
                    end else if (bf_q) begin
                        state_d = S_POLL_SETUP;
                        cnt_d   = LD_SETUP;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RST) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            dout_q  <= 8'h00;
`ifdef LCD1602_BUSY_POLL_EN
            rw_q    <= 1'b0;
            drive_q <= 1'b1;
            bf_q    <= 1'b0;
            poll_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            dout_q  <= dout_d;
`ifdef LCD1602_BUSY_POLL_EN
            rw_q    <= rw_d;
            drive_q <= drive_d;
            bf_q    <= bf_d;
            poll_q  <= poll_d;
`endif
        end
    end

    assign oDone      = done_q;
    assign oReady     = ready_q;
    assign LCD1602_RS = rs_q;
    assign LCD1602_EN = en_q;
`ifdef LCD1602_BUSY_POLL_EN
    assign LCD1602_RW = rw_q;
    assign LCD1602_D  = drive_q ? dout_q : 8'hzz;
`else
    assign LCD1602_RW = 1'b0;
    assign LCD1602_D  = dout_q;
`endif

endmodule

// File: tb/tb_lcd1602_bus_driver.sv
// tb/tb_lcd1602_bus_driver.sv - directed self-checking bench for lcd1602_bus_driver

module tb_lcd1602_bus_driver;

    localparam int T_POWERUP = 10;
    localparam int T_SETUP   = 2;
    localparam int T_EN      = 3;
    localparam int T_HOLD    = 2;
    localparam int T_EXEC    = 5;
    localparam int T_LONG    = 20;
`ifdef LCD1602_BUSY_POLL_EN
    localparam int LAT_NORM  = 1 + T_SETUP + T_EN + T_HOLD + T_SETUP + T_EN + T_HOLD;
    localparam int LAT_LONG  = LAT_NORM;
`else
    localparam int LAT_NORM  = 1 + T_SETUP + T_EN + T_HOLD + T_EXEC;
    localparam int LAT_LONG  = 1 + T_SETUP + T_EN + T_HOLD + T_LONG;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       call    = 1'b0;
    logic       rs_in   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       done;
    logic       ready;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    wire  [7:0] lcd_d;

    int checks = 0;
    int errors = 0;

`ifdef LCD1602_BUSY_POLL_EN
    logic bf_model = 1'b0;
    // The LCD only drives the bus while a read strobe is high.
    assign lcd_d = (lcd_en && lcd_rw) ? {bf_model, 7'b0} : 8'hzz;
`endif

    always #5 clk = ~clk;

    lcd1602_bus_driver #(
        .T_POWERUP_CYC (T_POWERUP),
        .T_SETUP_CYC   (T_SETUP),
        .T_EN_CYC      (T_EN),
        .T_HOLD_CYC    (T_HOLD),
        .T_EXEC_CYC    (T_EXEC),
        .T_LONG_CYC    (T_LONG)
    ) dut (
        .CLOCK      (clk),
        .RST        (rst),
        .iCall      (call),
        .iRS        (rs_in),
        .iDATA      (data_in),
        .oDone      (done),
        .oReady     (ready),
        .LCD1602_RS (lcd_rs),
        .LCD1602_RW (lcd_rw),
        .LCD1602_EN (lcd_en),
        .LCD1602_D  (lcd_d)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and observes it; cycle c is the cycle after
    // the c-th edge, the accept edge being the first.
    task automatic do_request(input logic rs, input logic [7:0] data,
                              output int done_cyc, output int en_cyc,
                              output int en_bad, output int pulses);
        done_cyc = 0;
        en_cyc   = 0;
        en_bad   = 0;
        pulses   = 0;
        call     = 1'b1;
        rs_in    = rs;
        data_in  = data;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) begin
                rs_in   = ~rs;
                data_in = ~data;
            end
            if (lcd_en && !lcd_rw) begin
                en_cyc++;
                if (lcd_d !== data || lcd_rs !== rs) en_bad++;
            end
            if (done) begin
                pulses++;
                if (done_cyc == 0) done_cyc = c;
                call = 1'b0;
            end
            if (done_cyc != 0 && c >= done_cyc + 5) break;
        end
        call = 1'b0;
    endtask

    task automatic test_reset;
        int en_seen;
        en_seen = 0;
        rst = 1'b1; call = 1'b1; rs_in = 1'b1; data_in = 8'h41;
        tick(); tick();
        checks++;
        if ({done, ready, lcd_rs, lcd_rw, lcd_en, lcd_d} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {done, ready, lcd_rs, lcd_rw, lcd_en, lcd_d});
        end
        rst = 1'b0;
        for (int i = 1; i < T_POWERUP; i++) begin
            tick();
            if (lcd_en) en_seen++;
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_early got %b want 0", ready);
        end
        tick();
        if (lcd_en) en_seen++;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise got %b want 1", ready);
        end
        checks++;
        if (en_seen !== 0) begin
            errors++;
            $display("FAIL pwrup_en got %0d want 0", en_seen);
        end
    endtask

    task automatic test_data_write;
        int d, e, b, p;
        do_request(1'b1, 8'h41, d, e, b, p);
        checks++;
        if (d !== LAT_NORM) begin
            errors++;
            $display("FAIL data_latency got %0d want %0d", d, LAT_NORM);
        end
        checks++;
        if (p !== 1) begin
            errors++;
            $display("FAIL data_pulses got %0d want 1", p);
        end
        checks++;
        if (e !== T_EN) begin
            errors++;
            $display("FAIL data_en_width got %0d want %0d", e, T_EN);
        end
        checks++;
        if (b !== 0) begin
            errors++;
            $display("FAIL data_bus got %0d bad cycles want 0", b);
        end
    endtask

    task automatic test_clear;
        logic       v_rs  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] v_dat [7] = '{8'h01, 8'h02, 8'h03, 8'h38, 8'h04, 8'h00, 8'h01};
        int         v_lat [7] = '{LAT_LONG, LAT_LONG, LAT_LONG, LAT_NORM, LAT_NORM, LAT_NORM, LAT_NORM};
        int d, e, b, p;
        for (int i = 0; i < 7; i++) begin
            do_request(v_rs[i], v_dat[i], d, e, b, p);
            checks++;
            if (d !== v_lat[i] || p !== 1 || b !== 0) begin
                errors++;
                $display("FAIL cmd_latency rs=%b data=%h got %0d/%0d/%0d want %0d/1/0",
                         v_rs[i], v_dat[i], d, p, b, v_lat[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int d, e, b, p;
        int tot_pulses, tot_en, tot_bad, lat_err;
        logic       rs;
        logic [7:0] dat;
        tot_pulses = 0; tot_en = 0; tot_bad = 0; lat_err = 0;
        for (int i = 0; i < 34; i++) begin
            dat = 8'h30 + 8'(i);
            rs  = i[0];
            if (i == 10) begin
                dat = 8'h01;
                rs  = 1'b0;
            end
            do_request(rs, dat, d, e, b, p);
            tot_pulses += p;
            tot_en     += e;
            tot_bad    += b;
            if (d != ((i == 10) ? LAT_LONG : LAT_NORM)) lat_err++;
        end
        checks++;
        if (tot_pulses !== 34) begin
            errors++;
            $display("FAIL seq_done_count got %0d want 34", tot_pulses);
        end
        checks++;
        if (tot_en !== 34 * T_EN) begin
            errors++;
            $display("FAIL seq_en_cycles got %0d want %0d", tot_en, 34 * T_EN);
        end
        checks++;
        if (tot_bad !== 0) begin
            errors++;
            $display("FAIL seq_bus got %0d bad cycles want 0", tot_bad);
        end
        checks++;
        if (lat_err !== 0) begin
            errors++;
            $display("FAIL seq_latency got %0d wrong want 0", lat_err);
        end
    endtask

    // iCall kept high through DONE: the following IDLE cycle accepts again.
    task automatic test_legal_b2b;
        int d1, d2, en_c;
        d1 = 0; d2 = 0; en_c = 0;
        call = 1'b1; rs_in = 1'b1; data_in = 8'h55;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (lcd_en && !lcd_rw) en_c++;
            if (done) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) begin
                    d2   = c;
                    call = 1'b0;
                end
            end
            if (d2 != 0 && c >= d2 + 5) break;
        end
        call = 1'b0;
        checks++;
        if (d1 !== LAT_NORM || d2 - d1 !== LAT_NORM + 1) begin
            errors++;
            $display("FAIL b2b_done got %0d,%0d want %0d,%0d", d1, d2, LAT_NORM, 2 * LAT_NORM + 1);
        end
        checks++;
        if (en_c !== 2 * T_EN) begin
            errors++;
            $display("FAIL b2b_en_cycles got %0d want %0d", en_c, 2 * T_EN);
        end
    endtask

`ifdef LCD1602_BUSY_POLL_EN
    task automatic test_busy_poll(input logic stuck);
        int d, rd_cyc, wr_cyc, bad;
        d = 0; rd_cyc = 0; wr_cyc = 0; bad = 0;
        bf_model = 1'b1;
        call = 1'b1; rs_in = 1'b0; data_in = 8'h0C;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (lcd_en && lcd_rw) begin
                rd_cyc++;
                if (lcd_rs !== 1'b0) bad++;
            end
            if (lcd_en && !lcd_rw) wr_cyc++;
            if (lcd_rw && !lcd_en && lcd_d !== 8'hzz) bad++;
            bf_model = stuck || (rd_cyc / T_EN < 2);
            if (done && d == 0) begin
                d    = c;
                call = 1'b0;
            end
            if (d != 0 && c >= d + 2) break;
        end
        call = 1'b0;
        bf_model = 1'b0;
        checks++;
        if (rd_cyc !== 3 * T_EN || wr_cyc !== T_EN || bad !== 0) begin
            errors++;
            $display("FAIL poll_reads stuck=%b got %0d/%0d/%0d want %0d/%0d/0",
                     stuck, rd_cyc, wr_cyc, bad, 3 * T_EN, T_EN);
        end
        checks++;
        if (d !== 1 + T_SETUP + T_EN + T_HOLD + T_LONG) begin
            errors++;
            $display("FAIL poll_done stuck=%b got %0d want %0d", stuck, d,
                     1 + T_SETUP + T_EN + T_HOLD + T_LONG);
        end
    endtask
`endif

    task automatic test_reset_mid;
        int done_seen, en_seen;
        done_seen = 0; en_seen = 0;
        call = 1'b1; rs_in = 1'b1; data_in = 8'hA5;
        tick(); tick(); tick();
        checks++;
        if (lcd_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_pulse_en got %b want 1", lcd_en);
        end
        rst = 1'b1;
        call = 1'b0;
        tick();
        checks++;
        if ({done, ready, lcd_rs, lcd_rw, lcd_en, lcd_d} !== 13'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %h want 0", {done, ready, lcd_rs, lcd_rw, lcd_en, lcd_d});
        end
        rst = 1'b0;
        for (int i = 1; i <= T_POWERUP + 5; i++) begin
            tick();
            if (done) done_seen++;
            if (lcd_en) en_seen++;
            if (i == T_POWERUP - 1) begin
                checks++;
                if (ready !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_ready_early got %b want 0", ready);
                end
            end
        end
        checks++;
        if (ready !== 1'b1 || done_seen !== 0 || en_seen !== 0) begin
            errors++;
            $display("FAIL mid_recover got ready=%b done=%0d en=%0d want 1/0/0", ready, done_seen, en_seen);
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_clear();
        test_back_to_back();
        test_legal_b2b();
`ifdef LCD1602_BUSY_POLL_EN
        test_busy_poll(1'b0);
        test_busy_poll(1'b1);
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
